alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Execute stage directly downstream of the register array: consumes its two read-data outputs plus an opcode and destination address.
- Produces a result and destination address in the form the register array's write port takes (data + address).
- Single-cycle logic/arithmetic ops, plus an iterative shift-add multiply.
- Valid/ready handshake on both sides so the control unit can stall on MUL.

Parameters:
- BITS_DATA, 32, operand/result width (matches register width)
- BITS_ADDR, 3, destination register address width (matches register-file address)
- BITS_OP, 3, opcode width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- inValid  input  1  operands/opcode valid
- inReady  output  1  block can accept a new operation
- opcode  input  BITS_OP  operation select
- operand1  input  BITS_DATA  from register-file read port 1
- operand2  input  BITS_DATA  from register-file read port 2
- dirrDestIn  input  BITS_ADDR  destination register address
- outValid  output  1  result valid
- outReady  input  1  writeback accepts result
- result  output  BITS_DATA  computed value
- dirrDestOut  output  BITS_ADDR  destination address carried with result
- zeroFlag  output  1  result == 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, inReady=1, outValid=0, result=0, dirrDestOut=0, zeroFlag=1, counter=0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed; result 1 if operand1<operand2, else 0.
  - 6 SLL: operand1 << operand2[$clog2(BITS_DATA)-1:0].
  - 7 MUL: low BITS_DATA bits of unsigned product.
- ADD/SUB wrap modulo 2^BITS_DATA; no overflow output.
- Accept: a transfer occurs on an edge where inValid && inReady. Operands, opcode and dirrDestIn are captured that edge; inputs are don't-care afterwards.
- FSM states: IDLE, MUL, DONE.
  - IDLE: inReady=1, outValid=0. On accept of op 0-6: compute, register result, go DONE. On accept of op 7: load multiplicand/multiplier, clear accumulator, counter=0, go MUL.
  - MUL: inReady=0. Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After BITS_DATA iterations, register acc into result and go DONE.
  - DONE: outValid=1, inReady=0. result, dirrDestOut and zeroFlag are held stable until the edge where outReady=1, then go IDLE.
- Latency (accept at edge N):
  - Single-cycle ops: outValid high from N+1.
  - MUL: outValid high from N+BITS_DATA+1 (N+33 at default).
- Throughput: one op per 2 cycles minimum (DONE→IDLE; no bypass from DONE to accept). Deliberate simplicity.
- Boundary conditions:
  - inValid while busy: ignored (inReady=0); the source must hold inValid.
  - outReady low in DONE: hold indefinitely, no output change.
  - outReady high outside DONE: no effect.
  - Reset mid-MUL or in DONE: return to reset values next edge; the pending result is discarded and never emitted.
  - SLL with shift amount ≥ BITS_DATA cannot occur (amount truncated to log2 bits).
  - MUL with either operand 0: still takes full BITS_DATA cycles, result 0.
- zeroFlag is registered with result; it reflects the held result.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams OP_ADD..OP_MUL.
  - FSM state encoding (IDLE=0, MUL=1, DONE=2, 2 bits).
  - BITS_DATA/BITS_ADDR defaults shared with the register array.
- Sub-module shift_add_multiplier: holds the MUL datapath and counter, with start/done pulse. The top FSM sequences it and multiplexes its output with the combinational ALU result.

Test Plan:
- After reset: inReady=1, outValid=0, result=0, zeroFlag=1. Then ADD 0xFFFFFFFF+0x00000001, dest 3 → next cycle result=0x00000000, zeroFlag=1, dirrDestOut=3, outValid=1.
- SUB 0x00000005-0x00000007 → result 0xFFFFFFFE. SLT 0xFFFFFFFF(-1) vs 0x00000001 → result 1. SLL 0x00000001 by operand2=0x00000023 (amount 3) → 0x00000008.
- MUL 0x0000FFFF*0x00010001, accepted at cycle N → outValid first high at N+33, result 0xFFFFFFFF; inReady=0 on cycles N+1..N+33. MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
- Backpressure: XOR 0xAAAAAAAA^0x55555555, outReady=0 for 5 cycles → result 0xFFFFFFFF stable, outValid=1, new inValid ignored. outReady=1 → IDLE next edge, then the new op is accepted.
- Reset asserted at cycle 10 of a MUL → next edge all outputs at reset values. outValid never rises for the aborted op; a following ADD 2+3 → result 5.
- Randomized back-to-back ops with random outReady gaps against a reference model: every accepted op is emitted exactly once, in order, with the correct dirrDestOut.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths common with the register array,
// ALU opcode values and the execute-stage FSM state encoding.
package cpu_pkg;

    localparam int BITS_DATA_DEF = 32;
    localparam int BITS_ADDR_DEF = 3;
    localparam int BITS_OP_DEF   = 3;

    localparam logic [BITS_OP_DEF-1:0] OP_ADD = 3'd0;
    localparam logic [BITS_OP_DEF-1:0] OP_SUB = 3'd1;
    localparam logic [BITS_OP_DEF-1:0] OP_AND = 3'd2;
    localparam logic [BITS_OP_DEF-1:0] OP_OR  = 3'd3;
    localparam logic [BITS_OP_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [BITS_OP_DEF-1:0] OP_SLT = 3'd5;
    localparam logic [BITS_OP_DEF-1:0] OP_SLL = 3'd6;
    localparam logic [BITS_OP_DEF-1:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Execute-stage handshake bus.
//   Issue side : inValid/inReady, opcode, operand1, operand2, dirrDestIn
//   Result side: outValid/outReady, result, dirrDestOut, zeroFlag
// The slave modport is the ALU; the master modport is the control/writeback side.
interface alu_multicycle_if
    import cpu_pkg::*;
#(
    parameter int BITS_DATA = BITS_DATA_DEF,
    parameter int BITS_ADDR = BITS_ADDR_DEF,
    parameter int BITS_OP   = BITS_OP_DEF
);
    logic                 inValid;
    logic                 inReady;
    logic [BITS_OP-1:0]   opcode;
    logic [BITS_DATA-1:0] operand1;
    logic [BITS_DATA-1:0] operand2;
    logic [BITS_ADDR-1:0] dirrDestIn;
    logic                 outValid;
    logic                 outReady;
    logic [BITS_DATA-1:0] result;
    logic [BITS_ADDR-1:0] dirrDestOut;
    logic                 zeroFlag;

    modport slave (
        input  inValid, opcode, operand1, operand2, dirrDestIn, outReady,
        output inReady, outValid, result, dirrDestOut, zeroFlag
    );

    modport master (
        output inValid, opcode, operand1, operand2, dirrDestIn, outReady,
        input  inReady, outValid, result, dirrDestOut, zeroFlag
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier producing the low BITS_DATA bits of an
// unsigned product. A start pulse loads the operands; exactly BITS_DATA
// iterations follow, and done pulses during the last one with product
// already including that final partial product.
//   clk, reset   : clock, synchronous active-high reset
//   start        : load multiplicand/multiplier, clear accumulator
//   multiplicand : operand shifted left each iteration
//   multiplier   : operand shifted right each iteration (LSB gates the add)
//   done         : high in the final iteration cycle
//   product      : accumulator plus the current partial product
module shift_add_multiplier
    import cpu_pkg::*;
#(
    parameter int BITS_DATA = BITS_DATA_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS_DATA-1:0] multiplicand,
    input  logic [BITS_DATA-1:0] multiplier,
    output logic                 done,
    output logic [BITS_DATA-1:0] product
);
    localparam int CNT_W = (BITS_DATA > 1) ? $clog2(BITS_DATA) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BITS_DATA - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [BITS_DATA-1:0] mcand_r;
    logic [BITS_DATA-1:0] mplier_r;
    logic [BITS_DATA-1:0] acc_r;
    logic [BITS_DATA-1:0] acc_sum_s;
    logic [CNT_W-1:0]     count_r;
    logic                 busy_r;

    // Accumulator plus the partial product selected by the multiplier LSB
    always_comb begin
        acc_sum_s = acc_r;
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
    end

    assign done    = busy_r && (count_r == LAST_COUNT);
    assign product = acc_sum_s;

    // Operand load on start, then one shift-add iteration per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= multiplicand;
            mplier_r <= multiplier;
            acc_r    <= '0;
            count_r  <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (done) begin
                busy_r  <= 1'b0;
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Execute stage: single-cycle ALU ops plus an iterative multiply, with a
// valid/ready handshake on the issue and result sides. One op is in flight
// at a time; the result is held in DONE until writeback takes it.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_multicycle_if slave (issue + result handshakes)
module alu_multicycle
    import cpu_pkg::*;
#(
    parameter int BITS_DATA = BITS_DATA_DEF,
    parameter int BITS_ADDR = BITS_ADDR_DEF,
    parameter int BITS_OP   = BITS_OP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    alu_multicycle_if.slave   bus
);
    localparam int SHAMT_W = (BITS_DATA > 1) ? $clog2(BITS_DATA) : 1;
    localparam logic [BITS_DATA-1:0] DATA_ONE = BITS_DATA'(1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 in_ready_nxt_s;
    logic                 out_valid_nxt_s;
    logic [BITS_DATA-1:0] result_r;
    logic [BITS_ADDR-1:0] dest_r;
    logic                 zero_r;
    logic [BITS_OP-1:0]   op_s;
    logic [BITS_DATA-1:0] alu_s;
    logic [BITS_DATA-1:0] mul_product_s;
    logic                 accept_s;
    logic                 mul_start_s;
    logic                 mul_done_s;

    assign op_s        = bus.opcode;
    // in_ready_r is high exactly in IDLE, so this is the accept condition
    assign accept_s    = bus.inValid && in_ready_r;
    assign mul_start_s = accept_s && (op_s == OP_MUL);

    // Single-cycle ALU result for the opcode presented this cycle
    always_comb begin
        alu_s = '0;
        case (op_s)
            OP_ADD:  alu_s = bus.operand1 + bus.operand2;
            OP_SUB:  alu_s = bus.operand1 - bus.operand2;
            OP_AND:  alu_s = bus.operand1 & bus.operand2;
            OP_OR:   alu_s = bus.operand1 | bus.operand2;
            OP_XOR:  alu_s = bus.operand1 ^ bus.operand2;
            OP_SLT:  alu_s = ($signed(bus.operand1) < $signed(bus.operand2)) ? DATA_ONE : '0;
            OP_SLL:  alu_s = bus.operand1 << bus.operand2[SHAMT_W-1:0];
            default: alu_s = '0;
        endcase
    end

    shift_add_multiplier #(
        .BITS_DATA (BITS_DATA)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start_s),
        .multiplicand (bus.operand1),
        .multiplier   (bus.operand2),
        .done         (mul_done_s),
        .product      (mul_product_s)
    );

    // FSM state register; handshake outputs are registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (op_s == OP_MUL) ? ST_MUL : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (bus.outReady) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the next state so they register with it
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            ST_MUL: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Result, destination and zero flag capture; held untouched in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= '0;
            dest_r   <= '0;
            zero_r   <= 1'b1;
        end else if (accept_s) begin
            dest_r <= bus.dirrDestIn;
            if (op_s != OP_MUL) begin
                result_r <= alu_s;
                zero_r   <= (alu_s == '0);
            end
        end else if ((state_r == ST_MUL) && mul_done_s) begin
            result_r <= mul_product_s;
            zero_r   <= (mul_product_s == '0);
        end
    end

    assign bus.inReady     = in_ready_r;
    assign bus.outValid    = out_valid_r;
    assign bus.result      = result_r;
    assign bus.dirrDestOut = dest_r;
    assign bus.zeroFlag    = zero_r;
endmodule
